ysyx_220053_ifu: RTL and testbench

Instruction fetch unit for the ysyx_220053 core, sitting directly upstream of the decode unit. It owns the fetch PC, issues in-order word requests to instruction memory over a valid/ready request channel, and reorders nothing: responses arrive in order. Each response is buffered with its PC in a small FIFO and presented to decode as `instr_o`/`pc_o` under a valid/ready handshake. Redirects from execute (jumps, branches, traps) flush all fetched and in-flight instructions.

---
 rtl/ysyx_220053_ifu.sv | 212 +++++++++++++++++++++
 tb/tb_ysyx_220053_ifu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220053_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_220053_ifu -- instruction fetch unit
//
// Owns the fetch PC and issues in-order word requests to instruction memory.
// Each accepted request allocates a FIFO entry that holds its PC. The matching
// in-order response fills the entry with the instruction word. Decode sees the
// head entry once it is filled. A redirect frees every entry. Responses that
// are still owed to the old stream are counted in drop_cnt and discarded when
// they arrive.
//
// Optional feature macro: YSYX_220053_IFU_MISALIGN_CHK_EN
//   When defined, a redirect target with pc[1:0] != 0 raises a sticky
//   fetch_fault and halts issue until the next aligned redirect.
//   When undefined, the low two target bits are forced to zero and
//   fetch_fault is tied low.
//
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   imem_req_valid/ready/addr  fetch request channel (64-bit word address)
//   imem_rsp_valid/data        in-order responses, no backpressure
//   redirect_valid/pc          one-cycle restart pulse from execute
//   instr_valid/ready          handshake towards decode
//   instr_o, pc_o              head instruction and its PC
//   fetch_fault                misaligned redirect target (sticky)
// ----------------------------------------------------------------------------
module ysyx_220053_ifu #(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        fetch_fault
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);

    logic [63:0]           ent_pc_q   [FIFO_DEPTH];
    logic [63:0]           ent_pc_d   [FIFO_DEPTH];
    logic [31:0]           ent_data_q [FIFO_DEPTH];
    logic [31:0]           ent_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_filled_q, ent_filled_d;
    logic [AW-1:0]         head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0]         alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]         unfilled_cnt_q, unfilled_cnt_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic [63:0]           fetch_pc_q, fetch_pc_d;
    logic                  run_q;

    logic [63:0] redirect_tgt_s;
    logic [CW:0] occupancy_s, drop_sum_s;
    logic        fault_s, req_fire_s, rsp_fill_s, pop_s;

`ifdef YSYX_220053_IFU_MISALIGN_CHK_EN
    logic fault_q, fault_d;

    assign redirect_tgt_s = redirect_pc;
    assign fault_s        = fault_q;

    // Fault state follows the alignment of the latest redirect target.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = |redirect_pc[1:0];
        end else begin
            fault_d = fault_q;
        end
    end

    // Sticky fault register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign redirect_tgt_s = redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
    assign fault_s        = 1'b0;
`endif

    assign fetch_fault = fault_s;

    // Requests already allocated plus responses still owed to a flushed
    // stream both occupy memory-side slots, so both limit issue.
    assign occupancy_s    = {1'b0, alloc_cnt_q} + {1'b0, drop_cnt_q};
    assign imem_req_valid = run_q & (occupancy_s < DEPTH_W) & ~redirect_valid & ~fault_s;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire_s     = imem_req_valid & imem_req_ready;

    assign instr_valid = ent_filled_q[head_q];
    assign instr_o     = ent_data_q[head_q];
    assign pc_o        = ent_pc_q[head_q];

    // A redirect discards the head, so a simultaneous ready is not a pop.
    assign pop_s      = instr_valid & instr_ready & ~redirect_valid;
    assign rsp_fill_s = imem_rsp_valid & ~redirect_valid & (drop_cnt_q == CNT_ZERO)
                        & (unfilled_cnt_q != CNT_ZERO);
    assign drop_sum_s = {1'b0, drop_cnt_q} + {1'b0, unfilled_cnt_q};

    // Next-state logic for the FIFO, the counters and the fetch PC.
    always_comb begin
        ent_pc_d       = ent_pc_q;
        ent_data_d     = ent_data_q;
        ent_filled_d   = ent_filled_q;
        head_d         = head_q;
        tail_d         = tail_q;
        fill_d         = fill_q;
        alloc_cnt_d    = alloc_cnt_q;
        unfilled_cnt_d = unfilled_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        fetch_pc_d     = fetch_pc_q;
        if (redirect_valid) begin
            ent_filled_d   = {FIFO_DEPTH{1'b0}};
            head_d         = PTR_ZERO;
            tail_d         = PTR_ZERO;
            fill_d         = PTR_ZERO;
            alloc_cnt_d    = CNT_ZERO;
            unfilled_cnt_d = CNT_ZERO;
            fetch_pc_d     = redirect_tgt_s;
            // A response landing in this cycle belongs to the old stream.
            if (imem_rsp_valid && (drop_sum_s != {(CW + 1){1'b0}})) begin
                drop_cnt_d = CW'(drop_sum_s - (CW + 1)'(1));
            end else begin
                drop_cnt_d = CW'(drop_sum_s);
            end
        end else begin
            if (req_fire_s) begin
                ent_pc_d[tail_q]     = fetch_pc_q;
                ent_filled_d[tail_q] = 1'b0;
                tail_d               = tail_q + PTR_ONE;
                fetch_pc_d           = fetch_pc_q + 64'd4;
            end else begin
                tail_d = tail_q;
            end
            if (imem_rsp_valid && (drop_cnt_q != CNT_ZERO)) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            // A response with nothing outstanding is a protocol error and
            // leaves the FIFO untouched.
            if (rsp_fill_s) begin
                ent_data_d[fill_q]   = imem_rsp_data;
                ent_filled_d[fill_q] = 1'b1;
                fill_d               = fill_q + PTR_ONE;
            end else begin
                fill_d = fill_q;
            end
            if (pop_s) begin
                ent_filled_d[head_q] = 1'b0;
                head_d               = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            alloc_cnt_d    = alloc_cnt_q + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                         - (pop_s ? CNT_ONE : CNT_ZERO);
            unfilled_cnt_d = unfilled_cnt_q + (req_fire_s ? CNT_ONE : CNT_ZERO)
                                            - (rsp_fill_s ? CNT_ONE : CNT_ZERO);
        end
    end

    // State registers; run_q holds off the first request until one edge
    // after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_pc_q[i]   <= 64'd0;
                ent_data_q[i] <= 32'd0;
            end
            ent_filled_q   <= {FIFO_DEPTH{1'b0}};
            head_q         <= PTR_ZERO;
            tail_q         <= PTR_ZERO;
            fill_q         <= PTR_ZERO;
            alloc_cnt_q    <= CNT_ZERO;
            unfilled_cnt_q <= CNT_ZERO;
            drop_cnt_q     <= CNT_ZERO;
            fetch_pc_q     <= RESET_PC;
            run_q          <= 1'b0;
        end else begin
            ent_pc_q       <= ent_pc_d;
            ent_data_q     <= ent_data_d;
            ent_filled_q   <= ent_filled_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            fill_q         <= fill_d;
            alloc_cnt_q    <= alloc_cnt_d;
            unfilled_cnt_q <= unfilled_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            fetch_pc_q     <= fetch_pc_d;
            run_q          <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_220053_ifu -- directed bench for the instruction fetch unit.
// An in-bench memory model accepts every request and returns addr[31:0]
// after a configurable latency. A per-cycle vector table covers the
// post-reset stream. Hand-written sequences cover backpressure, flushes,
// misaligned redirects and mid-burst reset.
// ----------------------------------------------------------------------------
module tb_ysyx_220053_ifu;

    typedef struct {
        logic        rdy;
        logic        exp_rv;
        logic [63:0] exp_addr;
        logic        exp_iv;
        logic [63:0] exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        fetch_fault;

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          fire_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] data_q[$];
    int          due_q[$];
    vec_t        tbl[10];

    ysyx_220053_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample the request handshake, advance, then update the
    // memory model and drop any redirect pulse.
    task automatic cyc();
        logic        fire;
        logic [63:0] a;
        #1;
        fire = imem_req_valid & imem_req_ready;
        a    = imem_req_addr;
        @(posedge clk);
        #1;
        cyc_n++;
        if (fire) begin
            fire_cnt++;
            data_q.push_back(a[31:0]);
            due_q.push_back(cyc_n + mem_lat - 1);
        end
        if (due_q.size() > 0 && due_q[0] <= cyc_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
        redirect_valid = 1'b0;
    endtask

    // Assert reset (memory resets with the core), check reset outputs, release.
    task automatic reset_chk(input string tag);
        rst_n          = 1'b0;
        data_q.delete();
        due_q.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        fire_cnt       = 0;
        #1;
        chk({tag, "_rst_req_valid"}, imem_req_valid, 1'b0);
        chk({tag, "_rst_instr_valid"}, instr_valid, 1'b0);
        chk({tag, "_rst_instr_o"}, instr_o, 32'd0);
        chk({tag, "_rst_pc_o"}, pc_o, 64'd0);
        chk({tag, "_rst_fault"}, fetch_fault, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rst_hold_req_valid"}, imem_req_valid, 1'b0);
        rst_n = 1'b1;
    endtask

    // Apply the per-cycle vector table, starting the cycle after reset release.
    task automatic run_table(input string tag);
        for (int i = 0; i < 10; i++) begin
            instr_ready = tbl[i].rdy;
            #1;
            chk($sformatf("%s_v%0d_req_valid", tag, i), imem_req_valid, tbl[i].exp_rv);
            if (tbl[i].exp_rv) begin
                chk($sformatf("%s_v%0d_req_addr", tag, i), imem_req_addr, tbl[i].exp_addr);
            end
            chk($sformatf("%s_v%0d_instr_valid", tag, i), instr_valid, tbl[i].exp_iv);
            if (tbl[i].exp_iv) begin
                chk($sformatf("%s_v%0d_pc", tag, i), pc_o, tbl[i].exp_pc);
                chk($sformatf("%s_v%0d_instr", tag, i), {32'd0, instr_o},
                    {32'd0, tbl[i].exp_pc[31:0]});
            end
            cyc();
        end
        instr_ready = 1'b1;
    endtask

    // Called in cycle N+1 after a redirect in cycle N: every delivered
    // instruction must come from the new stream, in order, first one in
    // cycle N+exp_first.
    task automatic watch(input logic [63:0] start, input int exp_first, input string tag);
        int          first;
        logic [63:0] exp;
        first = 0;
        exp   = start;
        for (int i = 1; i <= 12; i++) begin
            if (i > 1) cyc();
            if (instr_valid) begin
                if (first == 0) first = i;
                chk({tag, "_pc"}, pc_o, exp);
                chk({tag, "_instr"}, {32'd0, instr_o}, {32'd0, exp[31:0]});
                exp = exp + 64'd4;
            end
        end
        chk({tag, "_first_cycle"}, 64'(first), 64'(exp_first));
    endtask

    initial begin
        int fires_before;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        instr_ready    = 1'b1;

        // Post-reset stream with a 1-cycle memory; one ready=0 cycle at v7.
        tbl[0] = '{1'b1, 1'b0, 64'h0,           1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 64'h8000_0000,   1'b0, 64'h0};
        tbl[2] = '{1'b1, 1'b1, 64'h8000_0004,   1'b0, 64'h0};
        tbl[3] = '{1'b1, 1'b1, 64'h8000_0008,   1'b1, 64'h8000_0000};
        tbl[4] = '{1'b1, 1'b1, 64'h8000_000C,   1'b1, 64'h8000_0004};
        tbl[5] = '{1'b1, 1'b1, 64'h8000_0010,   1'b1, 64'h8000_0008};
        tbl[6] = '{1'b1, 1'b1, 64'h8000_0014,   1'b1, 64'h8000_000C};
        tbl[7] = '{1'b0, 1'b1, 64'h8000_0018,   1'b1, 64'h8000_0010};
        tbl[8] = '{1'b1, 1'b1, 64'h8000_001C,   1'b1, 64'h8000_0010};
        tbl[9] = '{1'b1, 1'b1, 64'h8000_0020,   1'b1, 64'h8000_0014};

        #2;
        mem_lat = 1;
        reset_chk("por");
        run_table("stream");

        // Decode stalled: exactly FIFO_DEPTH requests, then drain in order.
        reset_chk("stall");
        instr_ready = 1'b0;
        repeat (10) cyc();
        chk("stall_fire_cnt", 64'(fire_cnt), 64'd4);
        chk("stall_req_valid", imem_req_valid, 1'b0);
        chk("stall_instr_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain_%0d_valid", i), instr_valid, 1'b1);
            chk($sformatf("drain_%0d_pc", i), pc_o, 64'h8000_0000 + 64'(4 * i));
            if (i == 1) begin
                chk("resume_req_valid", imem_req_valid, 1'b1);
                chk("resume_req_addr", imem_req_addr, 64'h8000_0010);
            end
            cyc();
        end

        // 3-cycle memory, redirect with two requests in flight.
        mem_lat = 3;
        reset_chk("lat3");
        repeat (3) cyc();
        redirect_pc    = 64'h8000_1000;
        redirect_valid = 1'b1;
        #1;
        chk("lat3_redirect_req_withdrawn", imem_req_valid, 1'b0);
        cyc();
        chk("lat3_new_req_addr", imem_req_addr, 64'h8000_1000);
        watch(64'h8000_1000, 5, "lat3_new");

        // Redirect coinciding with a response and a decode pop.
        mem_lat = 1;
        reset_chk("race");
        repeat (3) cyc();
        redirect_pc    = 64'h8000_2000;
        redirect_valid = 1'b1;
        cyc();
        chk("race_valid_after_flush", instr_valid, 1'b0);
        watch(64'h8000_2000, 3, "race_new");

        // Misaligned redirect target.
`ifdef YSYX_220053_IFU_MISALIGN_CHK_EN
        redirect_pc    = 64'h8000_0002;
        redirect_valid = 1'b1;
        cyc();
        chk("misalign_fault_set", fetch_fault, 1'b1);
        chk("misalign_req_halt", imem_req_valid, 1'b0);
        fires_before = fire_cnt;
        repeat (3) cyc();
        chk("misalign_fault_sticky", fetch_fault, 1'b1);
        chk("misalign_no_fires", 64'(fire_cnt), 64'(fires_before));
        chk("misalign_no_instr", instr_valid, 1'b0);
        redirect_pc    = 64'h8000_0100;
        redirect_valid = 1'b1;
        cyc();
        chk("align_fault_clear", fetch_fault, 1'b0);
        chk("align_req_addr", imem_req_addr, 64'h8000_0100);
        watch(64'h8000_0100, 3, "align_new");
`else
        redirect_pc    = 64'h8000_0002;
        redirect_valid = 1'b1;
        fires_before   = fire_cnt;
        cyc();
        chk("misalign_fault_tied", fetch_fault, 1'b0);
        chk("misalign_fetch_ran", 64'(fire_cnt > fires_before), 64'd0);
        chk("misalign_req_addr", imem_req_addr, 64'h8000_0000);
        watch(64'h8000_0000, 3, "misalign_new");
`endif

        // Reset in the middle of a running burst.
        chk("midrst_pre_valid", instr_valid, 1'b1);
        reset_chk("midrst");
        run_table("restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
